sha1_pad: RTL and testbench

- Upstream feeder for the SHA-1 compression pipeline.
- Accepts a message as a big-endian 32-bit word stream with a valid/ready handshake.
- Assembles 512-bit blocks and applies standard SHA-1 padding: 0x80 byte, zero fill, 64-bit big-endian bit length.
- Presents each block on block_o for the compression stage, with a last flag marking the final block of a message.

---
 rtl/sha1_pad.sv | 182 ++++++++++++++++++
 tb/tb_sha1_pad.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs a 32-bit big-endian word stream into 512-bit blocks and
// appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha1_pad #(
  parameter int unsigned LEN_W = 61
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [31:0]  word_i,
  input  logic         word_valid_i,
  input  logic         word_last_i,
  input  logic [1:0]   word_bytes_i,
  output logic         word_ready_o,
  output logic [511:0] block_o,
  output logic         block_valid_o,
  output logic         block_last_o,
  input  logic         block_ready_i
);

  typedef enum logic [1:0] {StFill, StEmit, StPad2} state_e;

  state_e             r_state, w_state_nxt;
  logic [31:0]        r_buf [16];
  logic [3:0]         r_widx;
  logic [LEN_W-1:0]   r_byte_cnt;
  logic               r_pend80;
  logic               r_defer;
  logic [511:0]       r_block;
  logic               r_block_valid;
  logic               r_block_last;

  logic               w_accept;
  logic               w_xfer;
  logic [2:0]         w_n;
  logic [LEN_W-1:0]   w_byte_cnt_add;
  logic [63:0]        w_len_new;
  logic [63:0]        w_len_cur;
  logic [31:0]        w_word_wr;
  logic               w_fits;
  logic [511:0]       w_blk;
  logic [511:0]       w_pad_blk;

  assign word_ready_o  = (r_state == StFill);
  assign block_o       = r_block;
  assign block_valid_o = r_block_valid;
  assign block_last_o  = r_block_last;

  assign w_accept       = word_valid_i & (r_state == StFill);
  assign w_xfer         = r_block_valid & block_ready_i;
  assign w_n            = (word_bytes_i == 2'd0) ? 3'd4 : {1'b0, word_bytes_i};
  assign w_byte_cnt_add = r_byte_cnt + LEN_W'(word_last_i ? w_n : 3'd4);
  assign w_len_new      = 64'({w_byte_cnt_add, 3'b000});
  assign w_len_cur      = 64'({r_byte_cnt, 3'b000});
  // Length fits in words 14/15 only if the data and the 0x80 marker end before word 14.
  assign w_fits         = ((w_n != 3'd4) && (r_widx <= 4'd13)) ||
                          ((w_n == 3'd4) && (r_widx <= 4'd12));

  always_comb begin
    w_word_wr = word_i;
    if (word_last_i) begin
      unique case (w_n)
        3'd1:    w_word_wr = {word_i[31:24], 8'h80, 16'h0000};
        3'd2:    w_word_wr = {word_i[31:16], 8'h80, 8'h00};
        3'd3:    w_word_wr = {word_i[31:8], 8'h80};
        default: w_word_wr = word_i;
      endcase
    end
  end

  always_comb begin
    w_blk = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(r_widx)) begin
        w_blk[511-32*k -: 32] = r_buf[k];
      end else if (k == int'(r_widx)) begin
        w_blk[511-32*k -: 32] = w_word_wr;
      end else if (word_last_i && (w_n == 3'd4) && (k == int'(r_widx) + 1)) begin
        w_blk[511-32*k -: 32] = 32'h8000_0000;
      end else begin
        w_blk[511-32*k -: 32] = 32'h0;
      end
    end
    if (word_last_i && w_fits) begin
      w_blk[63:0] = w_len_new;
    end
  end

  always_comb begin
    w_pad_blk          = '0;
    w_pad_blk[511:480] = r_pend80 ? 32'h8000_0000 : 32'h0;
    w_pad_blk[63:0]    = w_len_cur;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StFill: begin
        if (w_accept && (word_last_i || (r_widx == 4'd15))) w_state_nxt = StEmit;
      end
      StEmit: begin
        if (w_xfer) w_state_nxt = r_defer ? StPad2 : StFill;
      end
      StPad2: begin
        if (w_xfer) w_state_nxt = StFill;
      end
      default: w_state_nxt = StFill;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 16; k++) r_buf[k] <= 32'h0;
      r_widx        <= 4'd0;
      r_byte_cnt    <= '0;
      r_pend80      <= 1'b0;
      r_defer       <= 1'b0;
      r_block       <= '0;
      r_block_valid <= 1'b0;
      r_block_last  <= 1'b0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (w_accept) begin
            r_buf[r_widx] <= w_word_wr;
            r_byte_cnt    <= w_byte_cnt_add;
            if (word_last_i) begin
              if ((w_n == 3'd4) && (r_widx == 4'd15)) r_pend80 <= 1'b1;
              r_block       <= w_blk;
              r_block_valid <= 1'b1;
              r_block_last  <= w_fits;
              r_defer       <= ~w_fits;
              r_widx        <= 4'd0;
            end else if (r_widx == 4'd15) begin
              r_block       <= w_blk;
              r_block_valid <= 1'b1;
              r_block_last  <= 1'b0;
              r_defer       <= 1'b0;
              r_widx        <= 4'd0;
            end else begin
              r_widx <= r_widx + 4'd1;
            end
          end
        end
        StEmit: begin
          if (w_xfer) begin
            if (r_defer) begin
              r_block      <= w_pad_blk;
              r_block_last <= 1'b1;
              r_defer      <= 1'b0;
            end else begin
              r_block_valid <= 1'b0;
              r_widx        <= 4'd0;
              for (int k = 0; k < 16; k++) r_buf[k] <= 32'h0;
              if (r_block_last) begin
                r_byte_cnt <= '0;
                r_pend80   <= 1'b0;
              end
            end
          end
        end
        StPad2: begin
          if (w_xfer) begin
            r_block_valid <= 1'b0;
            r_widx        <= 4'd0;
            r_byte_cnt    <= '0;
            r_pend80      <= 1'b0;
            for (int k = 0; k < 16; k++) r_buf[k] <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_pad.sv
// Directed bench for sha1_pad: table of message lengths checked against a byte-level padding
// model, plus hand-written abc, backpressure and mid-message reset sequences.
module tb_sha1_pad;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  word_i;
  logic         word_valid_i;
  logic         word_last_i;
  logic [1:0]   word_bytes_i;
  logic         word_ready_o;
  logic [511:0] block_o;
  logic         block_valid_o;
  logic         block_last_o;
  logic         block_ready_i;

  sha1_pad #(.LEN_W(61)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_last_i  (word_last_i),
    .word_bytes_i (word_bytes_i),
    .word_ready_o (word_ready_o),
    .block_o      (block_o),
    .block_valid_o(block_valid_o),
    .block_last_o (block_last_o),
    .block_ready_i(block_ready_i)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] AbcBlk = {32'h6162_6380, {14{32'h0}}, 32'h0000_0018};

  typedef struct {
    int          nbytes;
    int          exp_blocks;
    logic [63:0] exp_len;
  } vec_t;

  vec_t         vecs [16];
  int           n_vec  = 0;
  int           n_miss = 0;
  logic [512:0] bq [$];

  // Every block handed downstream, with its last flag in bit 512.
  always @(negedge clk) begin
    if (rst_n && block_valid_o && block_ready_i) bq.push_back({block_last_o, block_o});
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input logic [1:0] nb);
    int guard;
    guard        = 0;
    word_i       = w;
    word_last_i  = last;
    word_bytes_i = nb;
    word_valid_i = 1'b1;
    @(negedge clk);
    while (!word_ready_o && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: got ready=0 want ready=1");
    end
    @(posedge clk);
    #1;
    word_valid_i = 1'b0;
  endtask

  task automatic run_msg(input int nbytes, input int exp_blocks, input logic [63:0] exp_len,
                         input int seed);
    logic [7:0]   msg [$];
    logic [7:0]   pad [$];
    logic [31:0]  w;
    logic [511:0] eb;
    logic [63:0]  bits;
    int           nw, nb, idx, g, nchk;
    string        tag;
    bq.delete();
    for (int i = 0; i < nbytes; i++) msg.push_back(8'(i * 7 + seed + 1));
    nw = (nbytes + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        idx = 4 * i + b;
        w   = {w[23:0], (idx < nbytes) ? msg[idx] : 8'hA5};
      end
      nb = nbytes - 4 * i;
      send_word(w, (i == nw - 1), (nb >= 4) ? 2'd0 : 2'(nb));
    end
    g = 0;
    while (bq.size() < exp_blocks && g < 500) begin
      g++;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    tag = $sformatf("n%0d", nbytes);
    chk({tag, "_nblocks"}, 512'(bq.size()), 512'(exp_blocks));
    // Reference padding built byte by byte.
    foreach (msg[i]) pad.push_back(msg[i]);
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bits = 64'(nbytes) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
    nchk = (bq.size() < exp_blocks) ? bq.size() : exp_blocks;
    for (int b = 0; b < nchk; b++) begin
      eb = '0;
      for (int i = 0; i < 64; i++) eb = {eb[503:0], pad[64 * b + i]};
      chk($sformatf("%s_blk%0d", tag, b), bq[b][511:0], eb);
      chk($sformatf("%s_last%0d", tag, b), 512'(bq[b][512]), 512'(b == exp_blocks - 1));
    end
    if (bq.size() == exp_blocks) chk({tag, "_len"}, 512'(bq[exp_blocks-1][63:0]), 512'(exp_len));
  endtask

  initial begin
    logic [511:0] exp_b1;
    vecs[0]  = '{1,   1, 64'h8};
    vecs[1]  = '{4,   1, 64'h20};
    vecs[2]  = '{5,   1, 64'h28};
    vecs[3]  = '{52,  1, 64'h1A0};
    vecs[4]  = '{53,  1, 64'h1A8};
    vecs[5]  = '{55,  1, 64'h1B8};
    vecs[6]  = '{1,   1, 64'h8};
    vecs[7]  = '{56,  2, 64'h1C0};
    vecs[8]  = '{57,  2, 64'h1C8};
    vecs[9]  = '{60,  2, 64'h1E0};
    vecs[10] = '{63,  2, 64'h1F8};
    vecs[11] = '{64,  2, 64'h200};
    vecs[12] = '{65,  2, 64'h208};
    vecs[13] = '{119, 2, 64'h3B8};
    vecs[14] = '{120, 3, 64'h3C0};
    vecs[15] = '{128, 3, 64'h400};

    rst_n         = 1'b0;
    word_i        = '0;
    word_valid_i  = 1'b0;
    word_last_i   = 1'b0;
    word_bytes_i  = '0;
    block_ready_i = 1'b1;
    #3;
    chk("rst_ready", 512'(word_ready_o), 512'(1));
    chk("rst_valid", 512'(block_valid_o), 512'(0));
    chk("rst_last", 512'(block_last_o), 512'(0));
    chk("rst_block", block_o, '0);
    #14 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // abc: one block, valid right after the accepting edge.
    send_word(32'h6162_6300, 1'b1, 2'd3);
    chk("abc_valid", 512'(block_valid_o), 512'(1));
    chk("abc_last", 512'(block_last_o), 512'(1));
    chk("abc_block", block_o, AbcBlk);
    repeat (3) @(posedge clk);
    #1;

    foreach (vecs[v]) run_msg(vecs[v].nbytes, vecs[v].exp_blocks, vecs[v].exp_len, v * 13);

    // Backpressure: a full data block stalled while the next word waits.
    block_ready_i = 1'b0;
    exp_b1 = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'hC0DE_0000 | 32'(i), 1'b0, 2'd0);
      exp_b1 = {exp_b1[479:0], 32'hC0DE_0000 | 32'(i)};
    end
    chk("bp_valid_rise", 512'(block_valid_o), 512'(1));
    word_i       = 32'hAABB_CCDD;
    word_last_i  = 1'b1;
    word_bytes_i = 2'd2;
    word_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_block%0d", c), block_o, exp_b1);
      chk($sformatf("bp_valid%0d", c), 512'(block_valid_o), 512'(1));
      chk($sformatf("bp_lastflag%0d", c), 512'(block_last_o), 512'(0));
      chk($sformatf("bp_wready%0d", c), 512'(word_ready_o), 512'(0));
      @(posedge clk);
      #1;
    end
    block_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_after_valid", 512'(block_valid_o), 512'(0));
    chk("bp_after_wready", 512'(word_ready_o), 512'(1));
    @(posedge clk);
    #1;
    word_valid_i = 1'b0;
    chk("bp_b2_valid", 512'(block_valid_o), 512'(1));
    chk("bp_b2_last", 512'(block_last_o), 512'(1));
    chk("bp_b2_block", block_o, {32'hAABB_8000, {14{32'h0}}, 32'h0000_0210});
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-message wipes outputs and partial state.
    for (int i = 0; i < 7; i++) send_word(32'h1234_5600 | 32'(i), 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_block", block_o, '0);
    chk("mrst_valid", 512'(block_valid_o), 512'(0));
    chk("mrst_last", 512'(block_last_o), 512'(0));
    chk("mrst_ready", 512'(word_ready_o), 512'(1));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h6162_6300, 1'b1, 2'd3);
    chk("mrst_abc_valid", 512'(block_valid_o), 512'(1));
    chk("mrst_abc_block", block_o, AbcBlk);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
